// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes and FSM state encodings for the SRAM responder.
package axi_lite_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_DELAY, R_RESP} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DELAY, W_RESP} w_state_e;
endpackage

// File: rtl/sram_bytewrite.sv
// Single-port-per-direction word memory: byte-enable write, registered read-first output.
module sram_bytewrite #(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [3:0]    wbe,
  input  logic [31:0]   wdata
);
  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Read and write of the same word on one edge return the old contents.
  always_ff @(posedge clk) begin
    if (re) rdata_q <= mem_q[raddr];
    for (int b = 0; b < 4; b++) begin
      if (we && wbe[b]) mem_q[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/axi_lite_sram.sv
// AXI4-Lite memory responder with independent read/write FSMs and programmable latency.
module axi_lite_sram #(
  parameter logic [31:0] BASE_ADDR     = 32'h8000_0000,
  parameter int          DEPTH_WORDS   = 1024,
  parameter int          READ_LATENCY  = 1,
  parameter int          WRITE_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [7:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);
  import axi_lite_pkg::*;

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);
  localparam logic [15:0] RL   = 16'(READ_LATENCY);
  localparam logic [15:0] WL   = 16'(WRITE_LATENCY);

  logic [31:0] ar_off, aw_off, ram_rdata;
  logic        ram_re, ram_we, unused_wstrb;
  assign ar_off       = araddr - BASE_ADDR;
  assign aw_off       = awaddr - BASE_ADDR;
  assign unused_wstrb = ^wstrb[7:4];

  // ---------------- read channel ----------------
  r_state_e    r_state_q, r_state_d;
  logic [15:0] r_cnt_q, r_cnt_d;
  logic [AW-1:0] ridx_q, ridx_d;
  logic        rerr_q, rerr_d, arready_q, arready_d, rvalid_q, rvalid_d;
  logic        rdata_en_q, rdata_en_d;
  logic [1:0]  rresp_q, rresp_d;

  always_comb begin
    r_state_d  = r_state_q;
    r_cnt_d    = r_cnt_q;
    ridx_d     = ridx_q;
    rerr_d     = rerr_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rdata_en_d = rdata_en_q;
    rresp_d    = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (arvalid && arready_q) begin
          ridx_d    = ar_off[AW+1:2];
          rerr_d    = !(ar_off < SPAN);
          r_cnt_d   = RL;
          arready_d = 1'b0;
          r_state_d = R_DELAY;
        end
      end
      R_DELAY: begin
        if (r_cnt_q == 16'd0) begin
          rvalid_d   = 1'b1;
          rdata_en_d = !rerr_q;
          rresp_d    = rerr_q ? RESP_SLVERR : RESP_OKAY;
          r_state_d  = R_RESP;
        end else begin
          r_cnt_d = r_cnt_q - 16'd1;
        end
      end
      R_RESP: begin
        if (rready) begin
          rvalid_d   = 1'b0;
          rdata_en_d = 1'b0;
          rresp_d    = RESP_OKAY;
          arready_d  = 1'b1;
          r_state_d  = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_q  <= R_IDLE;
      r_cnt_q    <= '0;
      ridx_q     <= '0;
      rerr_q     <= 1'b0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_en_q <= 1'b0;
      rresp_q    <= RESP_OKAY;
    end else begin
      r_state_q  <= r_state_d;
      r_cnt_q    <= r_cnt_d;
      ridx_q     <= ridx_d;
      rerr_q     <= rerr_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_en_q <= rdata_en_d;
      rresp_q    <= rresp_d;
    end
  end

  // ---------------- write channel ----------------
  w_state_e    w_state_q, w_state_d;
  logic [15:0] w_cnt_q, w_cnt_d;
  logic [AW-1:0] widx_q, widx_d;
  logic        werr_q, werr_d, aw_have_q, aw_have_d, w_have_q, w_have_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wbe_q, wbe_d;
  logic        awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        aw_hs, w_hs;

  assign aw_hs = awvalid && awready_q;
  assign w_hs  = wvalid && wready_q;

  always_comb begin
    w_state_d = w_state_q;
    w_cnt_d   = w_cnt_q;
    widx_d    = widx_q;
    werr_d    = werr_q;
    aw_have_d = aw_have_q;
    w_have_d  = w_have_q;
    wdata_d   = wdata_q;
    wbe_d     = wbe_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          widx_d    = aw_off[AW+1:2];
          werr_d    = !(aw_off < SPAN);
          aw_have_d = 1'b1;
        end
        if (w_hs) begin
          wdata_d  = wdata;
          wbe_d    = wstrb[3:0];
          w_have_d = 1'b1;
        end
        // A channel keeps its ready low once its beat has been captured.
        awready_d = !(aw_have_q || aw_hs);
        wready_d  = !(w_have_q || w_hs);
        if ((aw_have_q || aw_hs) && (w_have_q || w_hs)) begin
          aw_have_d = 1'b0;
          w_have_d  = 1'b0;
          w_cnt_d   = WL;
          w_state_d = W_DELAY;
        end
      end
      W_DELAY: begin
        if (w_cnt_q == 16'd0) begin
          bvalid_d  = 1'b1;
          bresp_d   = werr_q ? RESP_SLVERR : RESP_OKAY;
          w_state_d = W_RESP;
        end else begin
          w_cnt_d = w_cnt_q - 16'd1;
        end
      end
      W_RESP: begin
        if (bready) begin
          bvalid_d  = 1'b0;
          bresp_d   = RESP_OKAY;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_q <= W_IDLE;
      w_cnt_q   <= '0;
      widx_q    <= '0;
      werr_q    <= 1'b0;
      aw_have_q <= 1'b0;
      w_have_q  <= 1'b0;
      wdata_q   <= '0;
      wbe_q     <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      w_cnt_q   <= w_cnt_d;
      widx_q    <= widx_d;
      werr_q    <= werr_d;
      aw_have_q <= aw_have_d;
      w_have_q  <= w_have_d;
      wdata_q   <= wdata_d;
      wbe_q     <= wbe_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Memory is touched only on the single edge that leaves the delay state.
  assign ram_re = (r_state_q == R_DELAY) && (r_cnt_q == 16'd0) && !rerr_q;
  assign ram_we = (w_state_q == W_DELAY) && (w_cnt_q == 16'd0) && !werr_q;

  sram_bytewrite #(.DEPTH_WORDS(DEPTH_WORDS)) u_mem (
    .clk   (clk),
    .re    (ram_re),
    .raddr (ridx_q),
    .rdata (ram_rdata),
    .we    (ram_we),
    .waddr (widx_q),
    .wbe   (wbe_q),
    .wdata (wdata_q)
  );

  // The memory output register has no reset; mask it with a reset flop so rdata is 0 when idle or erroring.
  assign rdata   = rdata_en_q ? ram_rdata : 32'd0;
  assign rresp   = rresp_q;
  assign rvalid  = rvalid_q;
  assign arready = arready_q;
  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
endmodule

// File: tb/tb_axi_lite_sram.sv
// Scoreboard bench for axi_lite_sram: stimulus queues expectations, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_axi_lite_sram;
  localparam int RL = 1;
  localparam int WL = 1;
  localparam logic [1:0] OK = 2'b00;
  localparam logic [1:0] SE = 2'b10;

  localparam int S_ARREADY = 0, S_AWREADY = 1, S_WREADY = 2, S_RVALID = 3, S_BVALID = 4;
  localparam int S_RDATA = 5, S_RRESP = 6, S_BRESP = 7, S_RQ = 8, S_BQ = 9, S_TMO = 10;

  logic clk = 1'b0, rst = 1'b0;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [7:0]  wstrb;

  always #5 clk = ~clk;

  axi_lite_sram #(
    .BASE_ADDR(32'h8000_0000), .DEPTH_WORDS(1024), .READ_LATENCY(RL), .WRITE_LATENCY(WL)
  ) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct { logic [31:0] data; logic [1:0] resp; } r_exp_t;
  typedef struct { int id; logic [31:0] exp; string nm; } lvl_t;

  r_exp_t     r_q[$];
  logic [1:0] b_q[$];
  lvl_t       lvl_q[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sig_val(int id);
    case (id)
      S_ARREADY: return {31'd0, arready};
      S_AWREADY: return {31'd0, awready};
      S_WREADY:  return {31'd0, wready};
      S_RVALID:  return {31'd0, rvalid};
      S_BVALID:  return {31'd0, bvalid};
      S_RDATA:   return rdata;
      S_RRESP:   return {30'd0, rresp};
      S_BRESP:   return {30'd0, bresp};
      S_RQ:      return 32'(r_q.size());
      S_BQ:      return 32'(b_q.size());
      default:   return 32'd0;
    endcase
  endfunction

  function automatic string sig_name(int id);
    case (id)
      S_ARREADY: return "arready";
      S_AWREADY: return "awready";
      S_WREADY:  return "wready";
      S_RVALID:  return "rvalid";
      S_BVALID:  return "bvalid";
      S_RDATA:   return "rdata";
      S_RRESP:   return "rresp";
      S_BRESP:   return "bresp";
      S_RQ:      return "r_pending";
      S_BQ:      return "b_pending";
      default:   return "unknown";
    endcase
  endfunction

  // ---------------- monitor: the only place that counts comparisons ----------------
  int n_chk = 0, n_fail = 0;
  int ar_c = 0, aw_c = 0, w_c = 0;
  bit r_first = 0, b_first = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    lvl_t e;
    while (lvl_q.size() > 0) begin
      e = lvl_q.pop_front();
      if (e.id == S_TMO) begin
        n_chk++;
        n_fail++;
        $display("FAIL timeout waiting for %s (cycle %0d)", e.nm, cyc);
      end else begin
        chk(sig_name(e.id), sig_val(e.id), e.exp);
      end
    end
    if (rst) begin
      if (arvalid && arready) begin ar_c = cyc; r_first = 1; end
      if (awvalid && awready) begin aw_c = cyc; b_first = 1; end
      if (wvalid && wready)   begin w_c = cyc; b_first = 1; end
      if (rvalid) begin
        if (r_q.size() == 0) begin
          chk("r_unexpected", 32'd1, 32'd0);
        end else begin
          chk("rdata", rdata, r_q[0].data);
          chk("rresp", {30'd0, rresp}, {30'd0, r_q[0].resp});
          chk("arready_busy", {31'd0, arready}, 32'd0);
          if (r_first) chk("r_latency", 32'(cyc - ar_c - 1), 32'(RL + 1));
          r_first = 0;
          if (rready) begin
            $display("R txn: rdata=%h rresp=%b (cycle %0d)", rdata, rresp, cyc);
            void'(r_q.pop_front());
          end
        end
      end
      if (bvalid) begin
        if (b_q.size() == 0) begin
          chk("b_unexpected", 32'd1, 32'd0);
        end else begin
          chk("bresp", {30'd0, bresp}, {30'd0, b_q[0]});
          if (b_first) chk("b_latency", 32'(cyc - ((aw_c > w_c) ? aw_c : w_c) - 1), 32'(WL + 1));
          b_first = 0;
          if (bready) begin
            $display("B txn: bresp=%b (cycle %0d)", bresp, cyc);
            void'(b_q.pop_front());
          end
        end
      end
    end else begin
      r_first = 0;
      b_first = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic expect_lvl(int id, logic [31:0] v);
    lvl_q.push_back('{id: id, exp: v, nm: ""});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_outputs_zero();
    for (int i = S_ARREADY; i <= S_BRESP; i++) expect_lvl(i, 32'd0);
  endtask

  // Returns 1ns after the edge on which ready was high (the handshake edge).
  task automatic wait_ready(int id, string nm);
    logic [31:0] v;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      v = sig_val(id);
      tick();
      if (v[0]) return;
    end
    lvl_q.push_back('{id: S_TMO, exp: 32'd0, nm: nm});
  endtask

  task automatic wait_valid(int id, string nm);
    logic [31:0] v;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      v = sig_val(id);
      if (v[0]) begin
        tick();
        return;
      end
    end
    lvl_q.push_back('{id: S_TMO, exp: 32'd0, nm: nm});
    tick();
  endtask

  task automatic do_read(logic [31:0] a, logic [31:0] d, logic [1:0] r, int hold);
    r_q.push_back('{data: d, resp: r});
    araddr = a;
    arvalid = 1'b1;
    wait_ready(S_ARREADY, "arready");
    arvalid = 1'b0;
    araddr = 32'd0;
    rready = (hold == 0);
    wait_valid(S_RVALID, "rvalid");
    if (hold > 0) begin
      repeat (hold - 1) tick();
      rready = 1'b1;
      wait_valid(S_RVALID, "rvalid_hold");
    end
    rready = 1'b0;
    expect_lvl(S_ARREADY, 32'd1);
    expect_lvl(S_RVALID, 32'd0);
  endtask

  task automatic do_write(logic [31:0] a, logic [31:0] d, logic [7:0] s, logic [1:0] r, int lead);
    b_q.push_back(r);
    wdata = d;
    wstrb = s;
    wvalid = 1'b1;
    if (lead > 0) begin
      wait_ready(S_WREADY, "wready");
      wvalid = 1'b0;
      expect_lvl(S_WREADY, 32'd0);
      expect_lvl(S_AWREADY, 32'd1);
      expect_lvl(S_BVALID, 32'd0);
      repeat (lead - 1) tick();
    end
    awaddr = a;
    awvalid = 1'b1;
    bready = 1'b1;
    wait_ready(S_AWREADY, "awready");
    awvalid = 1'b0;
    wvalid = 1'b0;
    wait_valid(S_BVALID, "bvalid");
    bready = 1'b0;
    expect_lvl(S_AWREADY, 32'd1);
    expect_lvl(S_WREADY, 32'd1);
    expect_lvl(S_BVALID, 32'd0);
  endtask

  initial begin
    araddr = 0; arvalid = 0; rready = 0;
    awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
    expect_outputs_zero();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    expect_lvl(S_ARREADY, 32'd0);
    expect_lvl(S_AWREADY, 32'd0);
    tick();
    expect_lvl(S_ARREADY, 32'd1);
    expect_lvl(S_AWREADY, 32'd1);
    expect_lvl(S_WREADY, 32'd1);

    // Preload then read word 0.
    do_write(32'h8000_0000, 32'hDEAD_BEEF, 8'h0F, OK, 0);
    do_read (32'h8000_0000, 32'hDEAD_BEEF, OK, 0);

    // Byte strobes 0x05 merge bytes 0 and 2; upper strobe bits alone change nothing.
    do_write(32'h8000_0004, 32'hAABB_CCDD, 8'h0F, OK, 0);
    do_write(32'h8000_0004, 32'h1122_3344, 8'h05, OK, 0);
    do_read (32'h8000_0004, 32'hAA22_CC44, OK, 0);
    do_write(32'h8000_0004, 32'hFFFF_FFFF, 8'hF0, OK, 0);
    do_read (32'h8000_0004, 32'hAA22_CC44, OK, 0);

    // W two cycles ahead of AW.
    do_write(32'h8000_000C, 32'hCAFE_F00D, 8'h0F, OK, 2);
    do_read (32'h8000_000C, 32'hCAFE_F00D, OK, 0);

    // Range boundaries: below base, one past the end (aliases word 0 if mis-decoded), last word.
    do_read (32'h7FFF_FFFC, 32'h0000_0000, SE, 0);
    do_write(32'h8000_1000, 32'h1234_5678, 8'h0F, SE, 0);
    do_read (32'h8000_0000, 32'hDEAD_BEEF, OK, 0);
    do_write(32'h8000_0FFC, 32'hA5A5_5A5A, 8'h0F, OK, 0);
    do_read (32'h8000_0FFC, 32'hA5A5_5A5A, OK, 0);

    // Back-pressure on R for 5 cycles.
    do_read (32'h8000_000C, 32'hCAFE_F00D, OK, 5);

    // Reset while a write sits in the delay state.
    do_write(32'h8000_0008, 32'h5566_7788, 8'h0F, OK, 0);
    awaddr = 32'h8000_0008; awvalid = 1'b1;
    wdata = 32'h0BAD_0BAD; wstrb = 8'h0F; wvalid = 1'b1;
    wait_ready(S_AWREADY, "awready_rst");
    awvalid = 1'b0;
    wvalid = 1'b0;
    rst = 1'b0;
    expect_outputs_zero();
    repeat (2) tick();
    rst = 1'b1;
    expect_lvl(S_AWREADY, 32'd0);
    expect_lvl(S_WREADY, 32'd0);
    tick();
    expect_lvl(S_AWREADY, 32'd1);
    expect_lvl(S_WREADY, 32'd1);
    expect_lvl(S_ARREADY, 32'd1);
    do_read (32'h8000_0008, 32'h5566_7788, OK, 0);

    expect_lvl(S_RQ, 32'd0);
    expect_lvl(S_BQ, 32'd0);
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
